// File: rtl/rtc_bus_responder.sv
// rtc_bus_responder: responder for the multiplexed 8-bit RTC bus.
// An address phase latches a register index, and the following data phases
// read or write it over the shared dq bus.
// It keeps BCD time, date, weekday and week number, advanced once per second
// by an internal prescaler.
// Optional feature macro: RTC_CRONO_EN adds a BCD h:m:s countdown (crono)
// at 0x41-0x43, a control register at 0x02 and the irq flag. Without the
// macro those addresses are unmapped and irq is tied low.
module rtc_bus_responder #(
    parameter int CLK_PER_SEC = 100_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic       ad_n,
    inout  wire  [7:0] dq,
    output logic       tick_1hz,
    output logic       irq
);

    localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_PER_SEC - 1);

    logic [PW-1:0] presc;
    logic       wr_n_q;
    logic [7:0] addr_q;
    logic       rd_drive;
    logic [7:0] rd_data;
    logic [7:0] rd_mux;
    logic [7:0] wdata;
    logic       wr_rise;
    logic       addr_wr;
    logic       data_wr;

    logic [7:0] sec, min, hour, date, month, year, wday, week;
    logic [7:0] sec_n, min_n, hour_n, date_n, month_n, year_n, wday_n, week_n;
    logic [7:0] sec_i, min_i, hour_i, date_i, month_i, year_i, wday_i, week_i;
    logic       sec_cy, min_cy, hour_cy, date_cy, month_cy, year_cy, wday_cy, week_cy;
    logic       sec_c, min_c, hour_c, date_c, month_c, wday_c;
    logic       wr_sec;

    // BCD increment: fields at or past their limit (or holding invalid BCD
    // above it) wrap to the minimum and report a carry.
    function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] lo,
                                           input logic [7:0] hi);
        if (v >= hi)
            return {1'b1, lo};
        else if (v[3:0] >= 4'd9)
            return {1'b0, v[7:4] + 4'd1, 4'd0};
        else
            return {1'b0, v + 8'd1};
    endfunction

    // Last valid date of the month; February gets 29 when the BCD year is a
    // multiple of 4 (tens*10+units mod 4 equals (2*tens+units) mod 4).
    function automatic logic [7:0] days_in_month(input logic [7:0] m, input logic [7:0] y);
        logic [1:0] rem;
        rem = y[1:0] + {y[4], 1'b0};
        case (m)
            8'h02:                      return (rem == 2'd0) ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
            default:                    return 8'h31;
        endcase
    endfunction

    assign wdata    = dq;
    assign wr_rise  = wr_n && !wr_n_q;
    assign addr_wr  = !cs_n && !ad_n && wr_rise;
    assign data_wr  = !cs_n && ad_n && wr_rise;
    assign wr_sec   = data_wr && (addr_q == 8'h21);
    assign tick_1hz = (presc == PRESC_MAX);

    // The bus is only driven during a sampled read, and never while wr_n is low.
    assign dq = (rd_drive && wr_n) ? rd_data : 8'hzz;

    // Strobe history and the address latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_n_q <= 1'b1;
            addr_q <= 8'h00;
        end else begin
            wr_n_q <= wr_n;
            if (addr_wr)
                addr_q <= wdata;
        end
    end

    // Prescaler: wraps once per second, restarted by any seconds write.
    always_ff @(posedge clk) begin
        if (reset)
            presc <= '0;
        else if (wr_sec || tick_1hz)
            presc <= '0;
        else
            presc <= presc + PW'(1);
    end

    // Time/date cascade; a bus write to a field wins and kills its carry-out.
    always_comb begin
        {sec_cy, sec_i}     = bcd_inc(sec, 8'h00, 8'h59);
        {min_cy, min_i}     = bcd_inc(min, 8'h00, 8'h59);
        {hour_cy, hour_i}   = bcd_inc(hour, 8'h00, 8'h23);
        {date_cy, date_i}   = bcd_inc(date, 8'h01, days_in_month(month, year));
        {month_cy, month_i} = bcd_inc(month, 8'h01, 8'h12);
        {year_cy, year_i}   = bcd_inc(year, 8'h00, 8'h99);
        {wday_cy, wday_i}   = bcd_inc(wday, 8'h01, 8'h07);
        {week_cy, week_i}   = bcd_inc(week, 8'h01, 8'h53);

        sec_n   = wr_sec ? wdata : (tick_1hz ? sec_i : sec);
        sec_c   = tick_1hz && sec_cy && !wr_sec;

        min_n   = (data_wr && addr_q == 8'h22) ? wdata : (sec_c ? min_i : min);
        min_c   = sec_c && min_cy && !(data_wr && addr_q == 8'h22);

        hour_n  = (data_wr && addr_q == 8'h23) ? wdata : (min_c ? hour_i : hour);
        hour_c  = min_c && hour_cy && !(data_wr && addr_q == 8'h23);

        date_n  = (data_wr && addr_q == 8'h24) ? wdata : (hour_c ? date_i : date);
        date_c  = hour_c && date_cy && !(data_wr && addr_q == 8'h24);

        month_n = (data_wr && addr_q == 8'h25) ? wdata : (date_c ? month_i : month);
        month_c = date_c && month_cy && !(data_wr && addr_q == 8'h25);

        year_n  = (data_wr && addr_q == 8'h26) ? wdata : (month_c ? year_i : year);

        wday_n  = (data_wr && addr_q == 8'h27) ? wdata : (hour_c ? wday_i : wday);
        wday_c  = hour_c && wday_cy && !(data_wr && addr_q == 8'h27);

        week_n  = (data_wr && addr_q == 8'h28) ? wdata : (wday_c ? week_i : week);
    end

    // Time/date registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sec   <= 8'h00;
            min   <= 8'h00;
            hour  <= 8'h00;
            date  <= 8'h01;
            month <= 8'h01;
            year  <= 8'h00;
            wday  <= 8'h01;
            week  <= 8'h00;
        end else begin
            sec   <= sec_n;
            min   <= min_n;
            hour  <= hour_n;
            date  <= date_n;
            month <= month_n;
            year  <= year_n;
            wday  <= wday_n;
            week  <= week_n;
        end
    end

`ifdef RTC_CRONO_EN
    logic [7:0] csec, cmin, chour;
    logic [7:0] csec_n, cmin_n, chour_n;
    logic [7:0] csec_d, cmin_d, chour_d;
    logic       csec_b, cmin_b, chour_b;
    logic       run, run_n, irq_q, irq_n;
    logic       cro_zero, expire, dec, sb, mb, wr_ctrl;

    // BCD decrement: 00 wraps to the field maximum and borrows; values above
    // the maximum are pulled back to it.
    function automatic logic [8:0] bcd_dec(input logic [7:0] v, input logic [7:0] hi);
        if (v == 8'h00)
            return {1'b1, hi};
        else if (v > hi)
            return {1'b0, hi};
        else if (v[3:0] == 4'h0)
            return {1'b0, v[7:4] - 4'd1, 4'h9};
        else if (v[3:0] > 4'h9)
            return {1'b0, v[7:4], 4'h9};
        else
            return {1'b0, v - 8'd1};
    endfunction

    // Countdown, expiry and irq; a bus write to a crono field or control wins.
    always_comb begin
        wr_ctrl  = data_wr && (addr_q == 8'h02);
        cro_zero = (csec == 8'h00) && (cmin == 8'h00) && (chour == 8'h00);
        expire   = tick_1hz && run && cro_zero;
        dec      = tick_1hz && run && !cro_zero;
        {csec_b, csec_d}   = bcd_dec(csec, 8'h59);
        {cmin_b, cmin_d}   = bcd_dec(cmin, 8'h59);
        {chour_b, chour_d} = bcd_dec(chour, 8'h99);

        csec_n  = (data_wr && addr_q == 8'h41) ? wdata : (dec ? csec_d : csec);
        sb      = dec && csec_b && !(data_wr && addr_q == 8'h41);
        cmin_n  = (data_wr && addr_q == 8'h42) ? wdata : (sb ? cmin_d : cmin);
        mb      = sb && cmin_b && !(data_wr && addr_q == 8'h42);
        chour_n = (data_wr && addr_q == 8'h43) ? wdata : (mb ? chour_d : chour);

        run_n   = wr_ctrl ? wdata[0] : (expire ? 1'b0 : run);
        irq_n   = (irq_q && !(wr_ctrl && wdata[1])) || expire;
    end

    // Crono registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            csec  <= 8'h00;
            cmin  <= 8'h00;
            chour <= 8'h00;
            run   <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            csec  <= csec_n;
            cmin  <= cmin_n;
            chour <= chour_n;
            run   <= run_n;
            irq_q <= irq_n;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    // Read data selection for the currently latched address.
    always_comb begin
        rd_mux = 8'h00;
        case (addr_q)
            8'h21: rd_mux = sec;
            8'h22: rd_mux = min;
            8'h23: rd_mux = hour;
            8'h24: rd_mux = date;
            8'h25: rd_mux = month;
            8'h26: rd_mux = year;
            8'h27: rd_mux = wday;
            8'h28: rd_mux = week;
`ifdef RTC_CRONO_EN
            8'h41: rd_mux = csec;
            8'h42: rd_mux = cmin;
            8'h43: rd_mux = chour;
            8'h02: rd_mux = {7'b0, run};
`endif
            default: rd_mux = 8'h00;
        endcase
    end

    // Read drive: starts the clk after a sampled read, drops the clk after
    // rd_n or cs_n is sampled high.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_drive <= 1'b0;
            rd_data  <= 8'h00;
        end else begin
            rd_drive <= !cs_n && ad_n && !rd_n;
            rd_data  <= rd_mux;
        end
    end

endmodule
